// File: rtl/pb_debouncer_pkg.sv
// Shared types for the pushbutton debouncer: per-channel FSM state encoding
// and the default stability threshold.
package pb_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } db_state_e;

    localparam int DEFAULT_STABLE_CYCLES = 20;

    // Counter width able to hold values up to STABLE_CYCLES.
    function automatic int db_cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/pb_debouncer_channel.sv
// One debounce channel: two-flop synchronizer, then a stability-count FSM
// that commits a new level after STABLE_CYCLES consecutive enabled samples.
module debounce_channel
    import pb_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = db_cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic           sync1_q;
    logic           sync2_q;
    db_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           level_q;
    logic           rise_q;
    logic           fall_q;

    // Synchronizer runs every clock, independent of the sample tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Stability FSM; pulses self-clear every clock, state only moves on en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (en) begin
                case (state_q)
                    IDLE_LOW: begin
                        if (sync2_q) begin
                            if (STABLE_CYCLES == 1) begin
                                state_q <= IDLE_HIGH;
                                level_q <= 1'b1;
                                rise_q  <= 1'b1;
                            end else begin
                                state_q <= WAIT_HIGH;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (!sync2_q) begin
                            state_q <= IDLE_LOW;
                            cnt_q   <= CNT_ZERO;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE_HIGH;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    IDLE_HIGH: begin
                        if (!sync2_q) begin
                            if (STABLE_CYCLES == 1) begin
                                state_q <= IDLE_LOW;
                                level_q <= 1'b0;
                                fall_q  <= 1'b1;
                            end else begin
                                state_q <= WAIT_LOW;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    WAIT_LOW: begin
                        if (sync2_q) begin
                            state_q <= IDLE_HIGH;
                            cnt_q   <= CNT_ZERO;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE_LOW;
                            cnt_q   <= CNT_ZERO;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= CNT_ZERO;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/pb_debouncer.sv
// Pushbutton conditioning front end: Width independent debounce channels
// producing clean levels and single-cycle rise/fall strobes.
module pb_debouncer
    import pb_debouncer_pkg::*;
#(
    parameter int Width         = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [Width-1:0] pb_in,
    output logic [Width-1:0] pb_level,
    output logic [Width-1:0] pb_rise,
    output logic [Width-1:0] pb_fall
);

    for (genvar g = 0; g < Width; g++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .raw  (pb_in[g]),
            .level(pb_level[g]),
            .rise (pb_rise[g]),
            .fall (pb_fall[g])
        );
    end

endmodule
